// File: rtl/lab2_proc_int_muldiv_iter_pkg.sv
// lab2_proc_int_muldiv_iter_pkg: fn and FSM state encodings shared by the mul/div unit
// and by pipeline control when decoding mul/div instructions.
package lab2_proc_int_muldiv_iter_pkg;
   localparam logic [1:0] MULDIV_FN_MUL   = 2'd0;
   localparam logic [1:0] MULDIV_FN_MULHU = 2'd1;
   localparam logic [1:0] MULDIV_FN_DIVU  = 2'd2;
   localparam logic [1:0] MULDIV_FN_REMU  = 2'd3;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   function automatic logic fn_is_mul(input logic [1:0] fn);
      return !fn[1];
   endfunction
endpackage

// File: rtl/lab2_proc_int_muldiv_iter_ctrl.sv
// lab2_proc_int_muldiv_iter_ctrl: FSM, iteration counter, early-exit detect and
// val/rdy handshake for the iterative mul/div datapath.
module lab2_proc_int_muldiv_iter_ctrl
   import lab2_proc_int_muldiv_iter_pkg::*;
#(
   parameter int p_nbits      = 32,
   parameter bit p_early_exit = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic req_val,
   input  logic req_dz,
   input  logic resp_rdy,
   input  logic is_mul,
   input  logic b_next_zero,
   output logic req_rdy,
   output logic resp_val,
   output logic load,
   output logic step
);
   localparam int CW = $clog2(p_nbits) + 1;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last;
   always_comb begin
      last    = (cnt_q == CW'(p_nbits - 1)) || (p_early_exit && is_mul && b_next_zero);
      load    = (state_q == ST_IDLE) && req_val;
      step    = state_q == ST_CALC;
      state_d = (state_q == ST_IDLE) ? (req_val ? (req_dz ? ST_DONE : ST_CALC) : ST_IDLE)
              : (state_q == ST_CALC) ? (last ? ST_DONE : ST_CALC)
              : (resp_rdy ? ST_IDLE : ST_DONE);
      cnt_d   = load ? '0 : step ? cnt_q + CW'(1) : cnt_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // IDLE is the reset encoding, so hold req_rdy low while reset is held
   assign req_rdy  = (state_q == ST_IDLE) && reset;
   assign resp_val = state_q == ST_DONE;
endmodule

// File: rtl/lab2_proc_int_muldiv_iter.sv
// lab2_proc_int_muldiv_iter: iterative shift-add multiplier and restoring divider
// (MUL/MULHU/DIVU/REMU) behind a val/rdy request/response interface.
module lab2_proc_int_muldiv_iter
   import lab2_proc_int_muldiv_iter_pkg::*;
#(
   parameter int p_nbits      = 32,
   parameter bit p_early_exit = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_val,
   output logic               req_rdy,
   input  logic [1:0]         req_msg_fn,
   input  logic [p_nbits-1:0] req_msg_a,
   input  logic [p_nbits-1:0] req_msg_b,
   output logic               resp_val,
   input  logic               resp_rdy,
   output logic [p_nbits-1:0] resp_msg
);
   localparam int W = p_nbits;
   logic [1:0]     fn_q, fn_d;
   logic [2*W-1:0] ma_q, ma_d, acc_q, acc_d;
   logic [W-1:0]   b_q, b_d, quo_q, quo_d;
   logic [W:0]     rem_q, rem_d, rem_sh, rem_sub;
   logic           ge, load, step, req_dz, is_mul, b_next_zero;
   assign req_dz      = !fn_is_mul(req_msg_fn) && (req_msg_b == '0);
   assign is_mul      = fn_is_mul(fn_q);
   assign b_next_zero = (b_q >> 1) == '0;
   lab2_proc_int_muldiv_iter_ctrl #(
      .p_nbits      (p_nbits),
      .p_early_exit (p_early_exit)
   ) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .req_val     (req_val),
      .req_dz      (req_dz),
      .resp_rdy    (resp_rdy),
      .is_mul      (is_mul),
      .b_next_zero (b_next_zero),
      .req_rdy     (req_rdy),
      .resp_val    (resp_val),
      .load        (load),
      .step        (step)
   );
   // Divide by zero skips CALC: preload quotient with all-ones and remainder with a
   always_comb begin
      rem_sh  = {rem_q[W-1:0], quo_q[W-1]};
      rem_sub = rem_sh - {1'b0, b_q};
      ge      = rem_sh >= {1'b0, b_q};
      fn_d    = fn_q;
      ma_d    = ma_q;
      b_d     = b_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      if (load) begin
         fn_d  = req_msg_fn;
         ma_d  = {{W{1'b0}}, req_msg_a};
         b_d   = req_msg_b;
         acc_d = '0;
         rem_d = req_dz ? {1'b0, req_msg_a} : '0;
         quo_d = req_dz ? '1 : req_msg_a;
      end else if (step && is_mul) begin
         ma_d  = ma_q << 1;
         b_d   = b_q >> 1;
         acc_d = b_q[0] ? acc_q + ma_q : acc_q;
      end else if (step) begin
         rem_d = ge ? rem_sub : rem_sh;
         quo_d = {quo_q[W-2:0], ge};
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fn_q  <= '0;
         ma_q  <= '0;
         b_q   <= '0;
         acc_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
      end else begin
         fn_q  <= fn_d;
         ma_q  <= ma_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
      end
   end
   assign resp_msg = !resp_val ? '0
                   : (fn_q == MULDIV_FN_MUL)   ? acc_q[W-1:0]
                   : (fn_q == MULDIV_FN_MULHU) ? acc_q[2*W-1:W]
                   : (fn_q == MULDIV_FN_DIVU)  ? quo_q
                   : rem_q[W-1:0];
endmodule

// File: tb/tb_lab2_proc_int_muldiv_iter.sv
// tb_lab2_proc_int_muldiv_iter: directed vectors, back-pressure and reset sequences on
// 32-bit instances, plus randomized 8-bit sweeps against an arithmetic reference.
module tb_lab2_proc_int_muldiv_iter;
   import lab2_proc_int_muldiv_iter_pkg::*;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   logic [1:0]  fn;
   logic [31:0] ra, rb, m0, m1;
   logic [7:0]  m2, m3;
   logic [3:0]  rv, rr, rdy, val;
   int tests = 0;
   int fails = 0;
   lab2_proc_int_muldiv_iter #(.p_nbits(32), .p_early_exit(1'b0)) u0 (
      .clk(clk), .reset(reset), .req_val(rv[0]), .req_rdy(rdy[0]), .req_msg_fn(fn),
      .req_msg_a(ra), .req_msg_b(rb), .resp_val(val[0]), .resp_rdy(rr[0]), .resp_msg(m0));
   lab2_proc_int_muldiv_iter #(.p_nbits(32), .p_early_exit(1'b1)) u1 (
      .clk(clk), .reset(reset), .req_val(rv[1]), .req_rdy(rdy[1]), .req_msg_fn(fn),
      .req_msg_a(ra), .req_msg_b(rb), .resp_val(val[1]), .resp_rdy(rr[1]), .resp_msg(m1));
   lab2_proc_int_muldiv_iter #(.p_nbits(8), .p_early_exit(1'b0)) u2 (
      .clk(clk), .reset(reset), .req_val(rv[2]), .req_rdy(rdy[2]), .req_msg_fn(fn),
      .req_msg_a(ra[7:0]), .req_msg_b(rb[7:0]), .resp_val(val[2]), .resp_rdy(rr[2]), .resp_msg(m2));
   lab2_proc_int_muldiv_iter #(.p_nbits(8), .p_early_exit(1'b1)) u3 (
      .clk(clk), .reset(reset), .req_val(rv[3]), .req_rdy(rdy[3]), .req_msg_fn(fn),
      .req_msg_a(ra[7:0]), .req_msg_b(rb[7:0]), .resp_val(val[3]), .resp_rdy(rr[3]), .resp_msg(m3));

   typedef struct {
      int          inst;
      logic [1:0]  fn;
      logic [31:0] a, b, exp;
      int          lat;
   } vec_t;
   vec_t tbl[11];

   function automatic logic [31:0] msg_of(input int i);
      return i == 0 ? m0 : i == 1 ? m1 : i == 2 ? {24'b0, m2} : {24'b0, m3};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic start(input int i, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      fn = f;
      ra = a;
      rb = b;
      rv[i] = 1'b1;
      @(posedge clk);
      #1 rv[i] = 1'b0;
   endtask

   task automatic wait_resp(input int i, output logic [31:0] res, output int lat);
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (val[i]) break;
      end
      if (!val[i]) begin
         tests++;
         fails++;
         $display("FAIL timeout inst%0d: resp_val still 0 after %0d cycles, expected 1", i, lat);
      end
      res = msg_of(i);
   endtask

   task automatic ack(input int i);
      rr[i] = 1'b1;
      @(posedge clk);
      #1 rr[i] = 1'b0;
   endtask

   initial begin
      logic [31:0] res;
      logic [7:0]  a8, b8, e8;
      logic [15:0] p;
      logic [1:0]  f;
      int          lat, elat, bad, msb;
      tbl[0]  = '{0, MULDIV_FN_MUL,   32'd7,        32'd6,        32'd42,       33};
      tbl[1]  = '{0, MULDIV_FN_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      tbl[2]  = '{0, MULDIV_FN_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
      tbl[3]  = '{0, MULDIV_FN_DIVU,  32'd100,      32'd7,        32'd14,       33};
      tbl[4]  = '{0, MULDIV_FN_REMU,  32'd100,      32'd7,        32'd2,        33};
      tbl[5]  = '{0, MULDIV_FN_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1};
      tbl[6]  = '{0, MULDIV_FN_REMU,  32'd5,        32'd0,        32'd5,        1};
      tbl[7]  = '{1, MULDIV_FN_MUL,   32'd3,        32'd2,        32'd6,        3};
      tbl[8]  = '{1, MULDIV_FN_MUL,   32'd9,        32'd0,        32'd0,        2};
      tbl[9]  = '{1, MULDIV_FN_MULHU, 32'h80000000, 32'd4,        32'd2,        4};
      tbl[10] = '{1, MULDIV_FN_DIVU,  32'd100,      32'd7,        32'd14,       33};
      rv = '0;
      rr = '0;
      fn = '0;
      ra = '0;
      rb = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_req_rdy", 32'(rdy), 32'd0);
      chk("reset_resp_val", 32'(val), 32'd0);
      chk("reset_resp_msg", m0, 32'd0);
      reset = 1'b1;
      #1 chk("release_req_rdy", 32'(rdy), 32'hF);
      for (int k = 0; k < 11; k++) begin
         start(tbl[k].inst, tbl[k].fn, tbl[k].a, tbl[k].b);
         wait_resp(tbl[k].inst, res, lat);
         chk($sformatf("vec%0d_msg", k), res, tbl[k].exp);
         chk($sformatf("vec%0d_lat", k), 32'(lat), 32'(tbl[k].lat));
         ack(tbl[k].inst);
      end
      // back-pressure: hold the result 10 cycles, then release and issue another op
      start(0, MULDIV_FN_MUL, 32'd7, 32'd6);
      wait_resp(0, res, lat);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!val[0] || m0 !== 32'd42 || rdy[0]) bad++;
      end
      chk("bp_stable_cycles_bad", 32'(bad), 32'd0);
      ack(0);
      chk("bp_idle_req_rdy", 32'(rdy[0]), 32'd1);
      chk("bp_idle_resp_val", 32'(val[0]), 32'd0);
      start(0, MULDIV_FN_REMU, 32'd1000, 32'd33);
      wait_resp(0, res, lat);
      chk("bp_next_msg", res, 32'd10);
      ack(0);
      // reset pulse in cycle 10 of a divide discards it
      start(0, MULDIV_FN_DIVU, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1 chk("midrst_req_rdy", 32'(rdy[0]), 32'd0);
      chk("midrst_resp_msg", m0, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("midrst_release_rdy", 32'(rdy[0]), 32'd1);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (val[0]) bad++;
      end
      chk("midrst_no_resp", 32'(bad), 32'd0);
      start(0, MULDIV_FN_DIVU, 32'd9, 32'd3);
      wait_resp(0, res, lat);
      chk("postrst_divu", res, 32'd3);
      chk("postrst_lat", 32'(lat), 32'd33);
      ack(0);
      // 8-bit random sweep; reference built from plain arithmetic
      for (int i = 2; i < 4; i++) begin
         for (int k = 0; k < 150; k++) begin
            f  = 2'($urandom_range(0, 3));
            a8 = 8'($urandom_range(0, 255));
            b8 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            p  = 16'(a8) * 16'(b8);
            e8 = (f == MULDIV_FN_MUL)   ? p[7:0]
               : (f == MULDIV_FN_MULHU) ? p[15:8]
               : (f == MULDIV_FN_DIVU)  ? ((b8 == 0) ? 8'hFF : a8 / b8)
               : ((b8 == 0) ? a8 : a8 % b8);
            msb = 1;
            for (int j = 0; j < 8; j++) if (b8[j]) msb = j + 1;
            elat = (f[1] && b8 == 0) ? 1 : (!f[1] && i == 3) ? msb + 1 : 9;
            start(i, f, {24'b0, a8}, {24'b0, b8});
            wait_resp(i, res, lat);
            chk($sformatf("rnd_i%0d_%0d_fn%0d_%0d_%0d_msg", i, k, f, a8, b8), res, {24'b0, e8});
            chk($sformatf("rnd_i%0d_%0d_lat", i, k), 32'(lat), 32'(elat));
            ack(i);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
